// File: rtl/encode_pkg.sv
// Shared constants and types for the LZS encoder back end.
// Holds default widths, the bit-packer state encoding and the code lengths
// produced by the encode control stage.
package encode_pkg;

    localparam int OUT_WIDTH  = 32;
    localparam int ACC_WIDTH  = 64;
    localparam int CODE_WIDTH = 15;
    localparam int LEN_WIDTH  = 4;

    // Code lengths emitted by the control stage
    localparam int LEN_LIT   = 9;
    localparam int LEN_OFF_S = 9;
    localparam int LEN_OFF_L = 13;
    localparam int LEN_END   = 9;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_LAST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Number of bytes needed to hold a partial word of 'bits' bits (bits < 32)
    function automatic logic [2:0] tail_bytes(input logic [6:0] bits);
        return 3'((bits + 7'd7) >> 3);
    endfunction

endpackage

// File: rtl/encode_bitpack_shift.sv
// Purpose: ORs a right-justified code of up to 15 bits into a left-aligned accumulator after 'cnt' bits.
// Latency: combinational.
// Backpressure: none; caller guarantees cnt + len fits in the accumulator.
module encode_bitpack_shift #(
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 7,
    parameter int CODE_W = 15,
    parameter int LEN_W  = 4
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [LEN_W-1:0]  len,
    input  logic [CODE_W-1:0] code,
    output logic [ACC_W-1:0]  acc_out
);

    logic [CODE_W-1:0] mask;
    logic [CODE_W-1:0] code_m;
    logic [ACC_W-1:0]  code_ext;
    logic [CNT_W:0]    sh;

    // Keep only the len LSBs, then place bit len-1 just below the occupied bits
    always_comb begin
        mask     = ~({CODE_W{1'b1}} << len);
        code_m   = code & mask;
        code_ext = ACC_W'(code_m);
        sh       = (CNT_W+1)'(ACC_W) - {1'b0, cnt} - (CNT_W+1)'(len);
        acc_out  = acc_in | (code_ext << sh);
    end

endmodule

// File: rtl/encode_bitpack.sv
// Purpose: packs the variable-length code stream MSB-first into 32-bit words; zero-padded final word marked last.
// Latency: code visible in accumulator 1 cycle after enable; a full word reaches out_data on the following edge.
// Backpressure: out_valid/out_ready holds out_data stable; upstream cannot stall, so codes that do not fit are dropped and flagged by sticky overflow.
// Optional: define ENCODE_BITPACK_STAT_EN to add bit_total / word_total counters.
module encode_bitpack #(
    parameter int ACC_WIDTH = encode_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH = encode_pkg::OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt_output_enable,
    input  logic [3:0]           cnt_len,
    input  logic [12:0]          cnt_output,
    input  logic                 cnt_finish,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [2:0]           out_bytes,
    output logic                 overflow,
    output logic                 pack_done
`ifdef ENCODE_BITPACK_STAT_EN
    ,
    output logic [31:0]          bit_total,
    output logic [31:0]          word_total
`endif
);

    import encode_pkg::*;

    localparam int CNT_W = $clog2(ACC_WIDTH + 1);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W:0]   ACC_CNT = (CNT_W+1)'(ACC_WIDTH);

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_ext;
    logic [ACC_WIDTH-1:0]   acc_ins;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       cnt_ext;
    logic [CNT_W-1:0]       len_ext;
    logic [CODE_WIDTH-1:0]  code;
    logic                   ever_word;
    logic                   free;
    logic                   xfer;
    logic                   active;
    logic                   do_ext;
    logic                   code_vld;
    logic                   fits;
    logic                   do_app;
    logic                   drop;
    logic                   finishing;
    logic                   ext_last;

    // Per-cycle decisions: extract a full word, append or drop the incoming code
    always_comb begin
        free      = !out_valid || out_ready;
        xfer      = out_valid && out_ready;
        active    = (state == S_RUN) || (state == S_FLUSH);
        do_ext    = active && free && (count >= OUT_CNT);
        acc_ext   = do_ext ? (acc << OUT_WIDTH) : acc;
        cnt_ext   = do_ext ? (count - OUT_CNT) : count;
        len_ext   = CNT_W'(cnt_len);
        code      = CODE_WIDTH'(cnt_output);
        code_vld  = (state == S_RUN) && cnt_output_enable && (cnt_len != 4'd0);
        fits      = ({1'b0, cnt_ext} + {1'b0, len_ext}) <= ACC_CNT;
        do_app    = code_vld && fits;
        drop      = code_vld && !fits;
        // Stream is known to be over; a word that empties the accumulator is the last one
        finishing = (state == S_FLUSH) || ((state == S_RUN) && cnt_finish && !code_vld);
        ext_last  = do_ext && finishing && (count == OUT_CNT);
    end

    encode_bitpack_shift #(
        .ACC_W  (ACC_WIDTH),
        .CNT_W  (CNT_W),
        .CODE_W (CODE_WIDTH),
        .LEN_W  (LEN_WIDTH)
    ) u_shift (
        .acc_in  (acc_ext),
        .cnt     (cnt_ext),
        .len     (cnt_len),
        .code    (code),
        .acc_out (acc_ins)
    );

    // Accumulator, output word register and flush state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            acc       <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_bytes <= 3'd0;
            overflow  <= 1'b0;
            pack_done <= 1'b0;
            ever_word <= 1'b0;
        end else begin
            if (do_app) begin
                acc   <= acc_ins;
                count <= cnt_ext + len_ext;
            end else begin
                acc   <= acc_ext;
                count <= cnt_ext;
            end

            if (drop) begin
                overflow <= 1'b1;
            end

            if (xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (do_ext) begin
                out_data  <= acc[ACC_WIDTH-1 -: OUT_WIDTH];
                out_valid <= 1'b1;
                out_last  <= ext_last;
                out_bytes <= 3'd4;
                ever_word <= 1'b1;
            end

            case (state)
                S_RUN: begin
                    if (ext_last) begin
                        state <= S_LAST;
                    end else if (cnt_finish && !code_vld) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (ext_last) begin
                        state <= S_LAST;
                    end else if (count < OUT_CNT) begin
                        if (count != '0) begin
                            if (free) begin
                                out_data  <= acc[ACC_WIDTH-1 -: OUT_WIDTH];
                                out_valid <= 1'b1;
                                out_last  <= 1'b1;
                                out_bytes <= tail_bytes(7'(count));
                                ever_word <= 1'b1;
                                acc       <= '0;
                                count     <= '0;
                                state     <= S_LAST;
                            end
                        end else if (out_valid && !out_ready) begin
                            // Stalled word is the end of the stream
                            out_last <= 1'b1;
                            state    <= S_LAST;
                        end else if (ever_word) begin
                            // Final word already left the register; nothing more to send
                            pack_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            // Empty stream still produces one zero word
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            out_bytes <= 3'd1;
                            ever_word <= 1'b1;
                            state     <= S_LAST;
                        end
                    end
                end
                S_LAST: begin
                    if (xfer) begin
                        pack_done <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    pack_done <= 1'b1;
                end
            endcase
        end
    end

`ifdef ENCODE_BITPACK_STAT_EN
    // Running totals of stored code bits and accepted output words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_total  <= '0;
            word_total <= '0;
        end else begin
            if (do_app) begin
                bit_total <= bit_total + 32'(cnt_len);
            end
            if (xfer) begin
                word_total <= word_total + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_encode_bitpack.sv
// Directed bench for encode_bitpack: cycle vector table plus hand sequences.
// Inputs change on the falling edge, outputs are checked on the falling edge after each rising edge.
module tb_encode_bitpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_output_enable;
    logic [3:0]  cnt_len;
    logic [12:0] cnt_output;
    logic        cnt_finish;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [2:0]  out_bytes;
    logic        overflow;
    logic        pack_done;
`ifdef ENCODE_BITPACK_STAT_EN
    logic [31:0] bit_total;
    logic [31:0] word_total;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    encode_bitpack dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cnt_output_enable (cnt_output_enable),
        .cnt_len           (cnt_len),
        .cnt_output        (cnt_output),
        .cnt_finish        (cnt_finish),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .out_bytes         (out_bytes),
        .overflow          (overflow),
        .pack_done         (pack_done)
`ifdef ENCODE_BITPACK_STAT_EN
        ,
        .bit_total         (bit_total),
        .word_total        (word_total)
`endif
    );

    typedef struct {
        logic        en;
        logic [3:0]  len;
        logic [12:0] code;
        logic        fin;
        logic        rdy;
        logic        vld;
        logic [31:0] dat;
        logic        last;
        logic [2:0]  bytes;
        logic        ovf;
        logic        done;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [3:0] len, input logic [12:0] code,
                                input logic fin, input logic rdy, input logic vld, input logic [31:0] dat,
                                input logic last, input logic [2:0] bytes, input logic ovf, input logic done);
        vec_t v;
        v.en = en; v.len = len; v.code = code; v.fin = fin; v.rdy = rdy;
        v.vld = vld; v.dat = dat; v.last = last; v.bytes = bytes; v.ovf = ovf; v.done = done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] len, input logic [12:0] code,
                         input logic fin, input logic rdy);
        cnt_output_enable = en;
        cnt_len           = len;
        cnt_output        = code;
        cnt_finish        = fin;
        out_ready         = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_word(input string name, input logic [31:0] dat, input logic last, input logic [2:0] bytes);
        chk({name, ".vld"},   32'(out_valid), 32'd1);
        chk({name, ".dat"},   out_data, dat);
        chk({name, ".last"},  32'(out_last), 32'(last));
        chk({name, ".bytes"}, 32'(out_bytes), 32'(bytes));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 13'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];

        // Four len-9 codes then finish, consumer always ready
        tbl[0] = mk(1'b1, 4'd9, 13'h041, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 4'd9, 13'h042, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b0);
        tbl[2] = mk(1'b1, 4'd9, 13'h043, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b0);
        tbl[3] = mk(1'b1, 4'd9, 13'h044, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b0);
        tbl[4] = mk(1'b0, 4'd0, 13'h000, 1'b0, 1'b1, 1'b1, 32'h20908864, 1'b0, 3'd4, 1'b0, 1'b0);
        tbl[5] = mk(1'b0, 4'd0, 13'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b0);
        tbl[6] = mk(1'b0, 4'd0, 13'h000, 1'b1, 1'b1, 1'b1, 32'h40000000, 1'b1, 3'd1, 1'b0, 1'b0);
        tbl[7] = mk(1'b0, 4'd0, 13'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b1);
        tbl[8] = mk(1'b1, 4'd9, 13'h0FF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b1);

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 13'h0, 1'b0, 1'b0);
        step();
        chk("rst.vld",   32'(out_valid), 32'd0);
        chk("rst.dat",   out_data, 32'h0);
        chk("rst.last",  32'(out_last), 32'd0);
        chk("rst.bytes", 32'(out_bytes), 32'd0);
        chk("rst.ovf",   32'(overflow), 32'd0);
        chk("rst.done",  32'(pack_done), 32'd0);
        rst_n = 1'b1;

        // 20 bits of ones buffered, then reset; they must not reach the next word
        drive(1'b1, 4'd10, 13'h3FF, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 4'd0, 13'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst.vld",  32'(out_valid), 32'd0);
        chk("midrst.ovf",  32'(overflow), 32'd0);
        chk("midrst.done", 32'(pack_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].en, tbl[i].len, tbl[i].code, tbl[i].fin, tbl[i].rdy);
            step();
            chk($sformatf("tbl%0d.vld", i), 32'(out_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d.dat", i),   out_data, tbl[i].dat);
                chk($sformatf("tbl%0d.last", i),  32'(out_last), 32'(tbl[i].last));
                chk($sformatf("tbl%0d.bytes", i), 32'(out_bytes), 32'(tbl[i].bytes));
            end
            chk($sformatf("tbl%0d.ovf", i),  32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.done", i), 32'(pack_done), 32'(tbl[i].done));
        end

        // Overflow under stall: cnt_output is 13 bits wide, so a len-15 all-ones
        // code arrives as 2'b00 followed by 13 ones.
        do_reset();
        drive(1'b1, 4'd15, 13'h1FFF, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k < 4) begin
                chk($sformatf("ovf%0d.vld", k), 32'(out_valid), 32'd0);
            end else begin
                chk($sformatf("ovf%0d.vld", k), 32'(out_valid), 32'd1);
                chk($sformatf("ovf%0d.dat", k), out_data, 32'h3FFE7FFC);
            end
            chk($sformatf("ovf%0d.flag", k), 32'(overflow), (k >= 7) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 4'd0, 13'h0, 1'b0, 1'b0);
        step();
        chk("ovf.sticky", 32'(overflow), 32'd1);
        chk("ovf.hold",   out_data, 32'h3FFE7FFC);
        // Second word proves the dropped codes left the stored bits intact
        drive(1'b0, 4'd0, 13'h0, 1'b0, 1'b1);
        step();
        chk_word("ovf.w2", 32'hFFF9FFF3, 1'b0, 3'd4);

        // Asynchronous reset with a word pending and overflow set
        rst_n = 1'b0;
        #1;
        chk("arst.vld",  32'(out_valid), 32'd0);
        chk("arst.ovf",  32'(overflow), 32'd0);
        chk("arst.done", 32'(pack_done), 32'd0);
        chk("arst.dat",  out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Extract and append in the same cycle at count 43
        drive(1'b1, 4'd15, 13'h1555, 1'b0, 1'b1);
        step();
        drive(1'b1, 4'd15, 13'h0AAA, 1'b0, 1'b1);
        step();
        drive(1'b1, 4'd13, 13'h1ABC, 1'b0, 1'b1);
        step();
        chk("sim.noext", 32'(out_valid), 32'd0);
        drive(1'b1, 4'd9, 13'h00C3, 1'b0, 1'b1);
        step();
        chk_word("sim.w1", 32'h2AAA2AAB, 1'b0, 3'd4);
        drive(1'b0, 4'd0, 13'h0, 1'b1, 1'b1);
        step();
        chk("sim.gap", 32'(out_valid), 32'd0);
        step();
        chk_word("sim.w2", 32'h578C3000, 1'b1, 3'd3);
        step();
        chk("sim.vld",  32'(out_valid), 32'd0);
        chk("sim.done", 32'(pack_done), 32'd1);

        // Exactly two full words, finish arrives with the final code
        do_reset();
        drive(1'b1, 4'd13, 13'h1FFF, 1'b0, 1'b1);
        step();
        drive(1'b1, 4'd13, 13'h0000, 1'b0, 1'b1);
        step();
        drive(1'b1, 4'd13, 13'h1555, 1'b0, 1'b1);
        step();
        drive(1'b1, 4'd13, 13'h0AAA, 1'b0, 1'b1);
        step();
        chk_word("two.w1", 32'hFFF8002A, 1'b0, 3'd4);
        drive(1'b1, 4'd12, 13'h00F0, 1'b1, 1'b1);
        step();
        chk("two.gap", 32'(out_valid), 32'd0);
        drive(1'b0, 4'd0, 13'h0, 1'b1, 1'b1);
        step();
        chk_word("two.w2", 32'hAAAAA0F0, 1'b1, 3'd4);
        step();
        chk("two.vld",  32'(out_valid), 32'd0);
        chk("two.done", 32'(pack_done), 32'd1);
        step();
        chk("two.noextra", 32'(out_valid), 32'd0);

        // Empty stream: a single zero word with one valid byte
        do_reset();
        drive(1'b0, 4'd0, 13'h0, 1'b1, 1'b0);
        step();
        chk("zero.gap", 32'(out_valid), 32'd0);
        step();
        chk_word("zero.w", 32'h0, 1'b1, 3'd1);
        step();
        chk("zero.stall", 32'(out_valid), 32'd1);
        chk("zero.nodone", 32'(pack_done), 32'd0);
        drive(1'b0, 4'd0, 13'h0, 1'b1, 1'b1);
        step();
        chk("zero.vld",  32'(out_valid), 32'd0);
        chk("zero.done", 32'(pack_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
